mem_access_ctrl: RTL

Memory access sequencer for the CPU datapath. It sits between the control unit's two memory requesters, instruction fetch (IF) and load/store (LS), and the shared MAR/MDR/memory path. It arbitrates between the two requesters and drives the MAR address, the MDR `enable` and `read` controls and the memory strobes. It enforces a configurable minimum number of wait states and a ready-timeout, and returns a one-cycle completion pulse to the requester that owns the access.

---
 rtl/mem_access_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: arbitrates instruction fetch and load/store
// requesters onto the shared MAR/MDR/memory path, enforces minimum wait
// states and a ready timeout, and pulses done to the access owner.
//
// Handshake: if_req/ls_req are levels held until the matching done pulse;
// a request is accepted only in IDLE, when it is sampled at the clock edge.
// The address and write flag are captured at that edge, so later changes
// are ignored. The requester drops req on the edge that ends DONE.
// mem_ready is honoured only in ACCESS, and only once the wait count
// reaches WAIT_STATES.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mar_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mdr_enable,
  output logic                  mdr_read,
  output logic                  if_done,
  output logic                  ls_done,
  output logic                  err,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WS_C = CW'(WAIT_STATES);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic          owner_ls;   // 1 = current access belongs to LS
  logic          wr_q;       // 1 = current access is a store
  logic          fav_ls;     // round-robin: LS wins the next tie
  logic          err_q;      // current access ended by timeout
  logic [CW-1:0] cnt;        // ACCESS cycles elapsed, saturating
  logic          grant_any;
  logic          grant_ls;
  logic          honoured;
  logic          timed_out;

  // Arbitration and ACCESS exit conditions.
  always_comb begin
    grant_any = if_req | ls_req;
    grant_ls  = ls_req & (~if_req | fav_ls);
    honoured  = (state == ACCESS) & mem_ready & (cnt >= WS_C);
    timed_out = (state == ACCESS) & (cnt == TO_C) & ~honoured;
  end

  // State register; reset aborts any access with no done pulse.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-state outputs; all outputs are low in IDLE.
  always_comb begin
    state_nx   = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mdr_enable = 1'b0;
    mdr_read   = 1'b0;
    if_done    = 1'b0;
    ls_done    = 1'b0;
    err        = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:   if (grant_any) state_nx = ADDR;
      ADDR:   state_nx = ACCESS;
      ACCESS: begin
        mem_rd = ~wr_q;
        mem_wr = wr_q;
        // MDR captures read data on the edge that leaves ACCESS.
        mdr_enable = ~wr_q & honoured;
        mdr_read   = ~wr_q & honoured;
        if (honoured || timed_out) state_nx = DONE;
      end
      DONE: begin
        if_done  = ~owner_ls;
        ls_done  = owner_ls;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant capture, round-robin update, wait/timeout counting.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mar_addr <= '0;
      owner_ls <= 1'b0;
      wr_q     <= 1'b0;
      fav_ls   <= 1'b1;
      err_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          mar_addr <= grant_ls ? ls_addr : if_addr;
          owner_ls <= grant_ls;
          wr_q     <= grant_ls & ls_we;
          fav_ls   <= ~grant_ls;
        end
        ADDR: begin
          cnt   <= '0;
          err_q <= 1'b0;
        end
        ACCESS: begin
          if (cnt != TO_C) cnt <= cnt + 1'b1;
          if (timed_out) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
